picorv32_mem_arbiter: RTL

Shares one PicoRV32-native memory channel between up to four native-interface requesters: the CPU core, a debug module and a DMA/boot loader. Its downstream side drives the PicoRV32-to-FreeAHB adapter, so every requester reaches the AHB bus through a single AHB master. Arbitration is round-robin. A granted request is captured in registers and held stable until the downstream side returns `mem_ready`. After each completion the arbiter forces a guaranteed idle gap on `m_valid`, because the adapter only re-arms after it sees `mem_valid` low.

---
 rtl/picorv32_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// picorv32_mem_arbiter: round-robin sharing of one PicoRV32 native memory port
// Revision 1.0
// ============================================================================
module picorv32_mem_arbiter #(
  parameter int NPORTS     = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      s_valid,
  input  logic [NPORTS-1:0]      s_instr,
  input  logic [32*NPORTS-1:0]   s_addr,
  input  logic [32*NPORTS-1:0]   s_wdata,
  input  logic [4*NPORTS-1:0]    s_wstrb,
  output logic [NPORTS-1:0]      s_ready,
  output logic [31:0]            s_rdata,
  output logic                   m_valid,
  output logic                   m_instr,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  output logic [3:0]             m_wstrb,
  input  logic                   m_ready,
  input  logic [31:0]            m_rdata,
  output logic [NPORTS-1:0]      grant,
  output logic                   busy
);

  localparam int IDX_W = (NPORTS > 2) ? 2 : 1;
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NPORTS - 1);
  localparam logic [IDX_W:0]   NP        = (IDX_W + 1)'(NPORTS);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] grant_idx;
  logic [CNT_W-1:0] gap_cnt;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand_sum;
  logic             capture;
  logic             done;

  logic        instr_arr [NPORTS];
  logic [31:0] addr_arr  [NPORTS];
  logic [31:0] wdata_arr [NPORTS];
  logic [3:0]  wstrb_arr [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign instr_arr[g] = s_instr[g];
    assign addr_arr[g]  = s_addr[32*g +: 32];
    assign wdata_arr[g] = s_wdata[32*g +: 32];
    assign wstrb_arr[g] = s_wstrb[4*g +: 4];
  end

  // Search begins one past the last served port, wrapping modulo NPORTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand_sum = {1'b0, last} + (IDX_W + 1)'(k);
      if (cand_sum >= NP) begin
        cand_sum = cand_sum - NP;
      end
      if (!win_found && s_valid[cand_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          done       = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt <= CNT_ONE) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_instr   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      last      <= LAST_RST;
      gap_cnt   <= '0;
    end else begin
      busy <= (state_next != IDLE);
      if (capture) begin
        m_valid   <= 1'b1;
        m_instr   <= instr_arr[win_idx];
        m_addr    <= addr_arr[win_idx];
        m_wdata   <= wdata_arr[win_idx];
        m_wstrb   <= wstrb_arr[win_idx];
        grant     <= {{(NPORTS-1){1'b0}}, 1'b1} << win_idx;
        grant_idx <= win_idx;
      end
      if (done) begin
        m_valid <= 1'b0;
        grant   <= '0;
        last    <= grant_idx;
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - CNT_ONE;
      end
    end
  end

  // Completion is a same-cycle pulse to the owner; read data is a plain pass-through.
  assign s_ready = (state == BUSY && m_ready) ? grant : '0;
  assign s_rdata = m_rdata;

endmodule
`default_nettype wire
